// File: rtl/rip_nr1w_bram_pkg.sv
// rip_bram_pkg: shared types and helpers for the multi-read-port block RAM
package rip_bram_pkg;

    localparam int MAX_W = 1024;

    typedef enum logic {INIT, READY} bram_state_e;

    function automatic int strb_width(input int dw, input int bw);
        return dw / bw;
    endfunction

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_W-1:0] strb,
        input int               bw
    );
        logic [MAX_W-1:0] r;
        for (int b = 0; b < MAX_W; b++) r[b] = strb[b / bw] ? new_w[b] : old_w[b];
        return r;
    endfunction

endpackage

// File: rtl/rip_1r1w_bram_bank.sv
// rip_1r1w_bram_bank: simple-dual-port bank, byte-strobe write, read-first raw output
module rip_1r1w_bram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // strobed lane writes; read returns the pre-write word on an address collision
    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < STRB_WIDTH; k++)
                if (wstrb[k]) mem[waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
        if (re) dout <= mem[raddr];
    end

endmodule

// File: rtl/rip_nr1w_bram.sv
// rip_nr1w_bram: NUM_READ-port/1-write BRAM with zero-fill init and write-first forwarding (RIP_BRAM_OUTREG_EN adds an output stage)
module rip_nr1w_bram
    import rip_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_READ   = 2,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [NUM_READ-1:0]              re,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_READ-1:0]              rvalid
);

    localparam int SW = strb_width(DATA_WIDTH, BYTE_WIDTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (NUM_READ < 1) begin : g_bad_nr
        $error("NUM_READ must be at least 1");
    end
    if (DATA_WIDTH > MAX_W) begin : g_bad_dw
        $error("DATA_WIDTH exceeds byte_merge capacity");
    end

    bram_state_e           state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  ready;
    logic                  bank_we;
    logic [ADDR_WIDTH-1:0] bank_waddr;
    logic [SW-1:0]         bank_wstrb;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign ready      = state == READY;
    assign bank_we    = !ready | we;
    assign bank_waddr = ready ? waddr : init_cnt;
    assign bank_wstrb = ready ? wstrb : '1;
    assign bank_wdata = ready ? wdata : '0;

    // init sequencer: zero-fill one word per cycle, then open the block to traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
                state     <= READY;
                init_busy <= 1'b0;
            end
        end
    end

    // write data kept one cycle for merging into colliding reads
    always_ff @(posedge clk) begin
        wdata_q <= wdata;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        logic [ADDR_WIDTH-1:0] ra;
        logic                  rd;
        logic [DATA_WIDTH-1:0] dout;
        logic [DATA_WIDTH-1:0] merged;
        logic [DATA_WIDTH-1:0] hold_q;
        logic [SW-1:0]         fstrb_q;
        logic                  v_q;

        assign ra     = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd     = re[i] & ready;
        assign merged = DATA_WIDTH'(byte_merge(MAX_W'(dout), MAX_W'(wdata_q), MAX_W'(fstrb_q), BYTE_WIDTH));

        rip_1r1w_bram_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .BYTE_WIDTH(BYTE_WIDTH),
            .STRB_WIDTH(SW)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we),
            .waddr(bank_waddr),
            .wstrb(bank_wstrb),
            .wdata(bank_wdata),
            .re   (rd),
            .raddr(ra),
            .dout (dout)
        );

        // read valid plus which lanes of the same-cycle write must override the raw bank word
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q     <= 1'b0;
                fstrb_q <= '0;
            end else begin
                v_q     <= rd;
                fstrb_q <= (rd && we && ra == waddr) ? wstrb : '0;
            end
        end

        // last delivered word, held while the port is idle
        always_ff @(posedge clk) begin
            if (rst) hold_q <= '0;
            else if (v_q) hold_q <= merged;
        end

`ifdef RIP_BRAM_OUTREG_EN
        logic v2_q;

        // valid delayed to line up with the registered output word
        always_ff @(posedge clk) begin
            if (rst) v2_q <= 1'b0;
            else v2_q <= v_q;
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = hold_q;
        assign rvalid[i]                         = v2_q;
`else
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = v_q ? merged : hold_q;
        assign rvalid[i]                         = v_q;
`endif
    end

endmodule

// File: tb/tb_rip_nr1w_bram.sv
// tb_rip_nr1w_bram: randomized scoreboard bench for rip_nr1w_bram against an array model
module tb_rip_nr1w_bram;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NR    = 3;
    localparam int SW    = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_busy;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [SW-1:0]     wstrb;
    logic [DW-1:0]     wdata;
    logic [NR-1:0]     re;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rvalid;

    always #5 clk = ~clk;

    rip_nr1w_bram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_READ  (NR),
        .BYTE_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init_busy(init_busy),
        .we       (we),
        .waddr    (waddr),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] expq [NR][$];
    logic [DW-1:0] last_exp [NR];
    int            init_left = DEPTH;
    int            errors = 0;
    int            checks = 0;
    bit            started = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*AW-1:0] pack(input int a0, input int a1, input int a2);
        return {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    // monitor: every cycle compare busy flag, and either pop a delivered word or confirm the held one
    always @(negedge clk) begin
        if (started) begin
            check("init_busy", DW'(init_busy), DW'(init_left != 0));
            for (int i = 0; i < NR; i++) begin
                if (rvalid[i]) begin
                    if (expq[i].size() == 0) begin
                        check($sformatf("rvalid%0d_spurious", i), DW'(rvalid[i]), DW'(0));
                    end else begin
                        last_exp[i] = expq[i].pop_front();
                        check($sformatf("rdata%0d", i), rdata[i*DW +: DW], last_exp[i]);
                    end
                end else begin
                    check($sformatf("rdata%0d_hold", i), rdata[i*DW +: DW], last_exp[i]);
                end
            end
        end
    end

    task automatic step(input bit r, input bit w, input int wa, input logic [SW-1:0] ws,
                        input logic [DW-1:0] wd, input logic [NR-1:0] rv, input logic [NR*AW-1:0] ra);
        logic [DW-1:0] e;
        int a;
        rst   = r;
        we    = w;
        waddr = AW'(wa);
        wstrb = ws;
        wdata = wd;
        re    = rv;
        raddr = ra;
        if (!r && init_left == 0) begin
            for (int i = 0; i < NR; i++) begin
                if (rv[i]) begin
                    a = int'(ra[i*AW +: AW]);
                    e = mem[a];
                    if (w && a == wa)
                        for (int k = 0; k < SW; k++)
                            if (ws[k]) e[k*8 +: 8] = wd[k*8 +: 8];
                    expq[i].push_back(e);
                end
            end
            if (w)
                for (int k = 0; k < SW; k++)
                    if (ws[k]) mem[wa][k*8 +: 8] = wd[k*8 +: 8];
        end
        @(posedge clk);
        #1;
        if (r) begin
            init_left = DEPTH;
            for (int j = 0; j < DEPTH; j++) mem[j] = '0;
            for (int i = 0; i < NR; i++) begin
                expq[i].delete();
                last_exp[i] = '0;
            end
        end else if (init_left > 0) begin
            init_left--;
        end
    endtask

    task automatic idle(input logic [NR-1:0] rv, input logic [NR*AW-1:0] ra);
        step(0, 0, 0, '0, '0, rv, ra);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wstrb = '0; wdata = '0; re = '0; raddr = '0;
        step(1, 0, 0, '0, '0, '0, '0);
        started = 1;
        for (int n = 0; n < 7; n++) idle(3'b111, pack(1, 2, 3));
        step(1, 0, 0, '0, '0, '0, '0);
        for (int n = 0; n < 16; n++) idle(NR'($urandom_range(0, 7)), (NR*AW)'($urandom));
        for (int a = 0; a < DEPTH; a++) idle(3'b111, pack(a, DEPTH - 1 - a, (a + 5) % DEPTH));
        step(0, 1, 3, 4'hF, 32'hDEADBEEF, '0, '0);
        step(0, 1, 3, 4'b0010, 32'h0000AA00, '0, '0);
        idle(3'b001, pack(3, 0, 0));
        step(0, 1, 5, 4'hF, 32'hCAFEF00D, '0, '0);
        step(0, 1, 5, 4'b1100, 32'h12345678, 3'b011, pack(5, 5, 0));
        step(0, 1, 1, 4'hF, 32'h11, '0, '0);
        step(0, 1, 2, 4'hF, 32'h22, '0, '0);
        step(0, 1, 3, 4'hF, 32'h33, '0, '0);
        for (int n = 0; n < 3; n++) idle(3'b111, pack(1, 2, 3));
        idle(3'b101, pack(1, 2, 3));
        idle('0, '0);
        for (int n = 0; n < 400; n++) begin
            if (n == 200) step(1, 0, 0, '0, '0, '0, '0);
            else step(0, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), SW'($urandom_range(0, 15)),
                      $urandom, NR'($urandom_range(0, 7)), (NR*AW)'($urandom));
        end
        for (int n = 0; n < 4; n++) idle('0, '0);
        for (int i = 0; i < NR; i++) check($sformatf("drain%0d", i), DW'(expq[i].size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
